otp_keystream_gen: RTL and testbench
====================================

# otp_keystream_gen

- Generates the 8-bit one-time-pad bytes consumed by the `otp` input of the stream cipher datapath.
- Serialises a seeded 16-bit Galois LFSR one bit per cycle and assembles 8 bits into a byte.
- Presents each byte on a valid/ready handshake and holds it stable until it is consumed.
- Sits directly upstream of the XOR encrypt/decrypt stage; the same seed on both link ends yields identical pads.

## Interface
- `LFSR_W`, 16: LFSR state width.
- `TAPS`, 16'hB400: Galois feedback mask. Maximal-length; period 65535.
- `DEFAULT_SEED`, 16'hACE1: reset state of the LFSR; also substituted for an all-zero seed.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seed_load`  in  1  one-cycle strobe; loads `seed`. Accepted in any state.
- `seed`  in  LFSR_W  seed value, sampled when `seed_load`=1.
- `enable`  in  1  permits byte generation.
- `otp_ready`  in  1  consumer accepts the byte.
- `otp_valid`  out  1  `otp` holds a complete byte.
- `otp`  out  8  keystream byte.
- `busy`  out  1  high in GEN.
- `exhausted`  out  1  sticky keystream-reuse flag. Tied 0 when the guard is compiled out.

## Operation
- **LFSR step:**
  - `bit` = `lfsr[0]`
  - `lfsr` <= `(lfsr >> 1) ^ (bit ? TAPS : 0)`
  - The byte shift register takes `{sr[6:0], bit}`, so the first bit generated lands in `otp[7]`.
- **States:**
  - IDLE: unseeded.
  - ARMED: seeded, not generating.
  - GEN: 8 steps, counted by a 3-bit `bit_cnt`.
  - HOLD: byte presented.
  - EXHAUSTED: present only with the guard compiled in.
- **Transitions:**
  - IDLE -> ARMED on `seed_load`.
  - ARMED -> GEN when `enable`=1.
  - GEN -> HOLD after the step with `bit_cnt`=7; `otp` is latched from the final shift.
  - HOLD -> GEN on handshake (`otp_valid && otp_ready`) when `enable`=1.
  - HOLD -> ARMED on handshake when `enable`=0.
  - HOLD -> HOLD with no handshake; `otp` and the LFSR stay frozen.
- **`enable` deasserted in GEN:** the current byte completes. The stop takes effect at the next decision point.
- **`seed_load` takes priority** over every transition:
  - Next state is ARMED; the LFSR loads `seed`, or `DEFAULT_SEED` if `seed`==0.
  - `bit_cnt` and the shift register clear.
  - A partial byte is discarded.
  - A handshake in the same cycle still counts as a completed transfer, and the consumer keeps that byte.
- **Reset values:**
  - State IDLE, LFSR = `DEFAULT_SEED`, `bit_cnt`=0.
  - All outputs 0: `otp`=0, `otp_valid`=0, `busy`=0, `exhausted`=0.

## Timing
- `enable` high in ARMED at cycle t: GEN covers cycles t+1..t+8, and `otp_valid` rises at t+9.
- Back-to-back throughput: one byte per 9 cycles (8 GEN cycles + 1 handshake cycle in HOLD).
- `seed_load` at cycle t: ARMED at t+1, and `otp_valid`=0 from t+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`OTP_GEN_REUSE_GUARD_EN` defined:**
  - The loaded seed is registered.
  - After every GEN step, the new LFSR state is compared with that seed.
  - On a match the in-progress byte is discarded and the block enters EXHAUSTED with `exhausted`=1.
  - In EXHAUSTED, `otp_valid`=0 and `enable` is ignored.
  - The only exits are `seed_load` (which clears `exhausted`) and reset.
- **Undefined:** no seed register, no comparator, no EXHAUSTED state; `exhausted` is tied 0 and the LFSR wraps silently.

## Structure
- **Package `otp_pkg`:**
  - State enum.
  - `OTP_W`=8.
  - Default `TAPS` and `DEFAULT_SEED` constants, shared with the verification model.
- **Sub-module `otp_lfsr_core`:**
  - Holds the LFSR register, the zero-seed substitution and the step logic.
  - Ports: `load`, `step`, `seed` in; `state`, `bit` out.
- **Top level:** FSM, `bit_cnt`, byte shift register, handshake, and the guard.

## Test plan
1. Reset with `seed_load` and `seed`=16'hACE1, `enable`=1, `otp_ready`=1 -> first byte `otp`=8'h87 with `otp_valid` nine cycles after ARMED; LFSR = 16'hC2C4 afterwards.
2. `seed`=16'h0000 -> same behaviour as test 1: `otp`=8'h87.
3. `otp_ready`=0 for 20 cycles in HOLD -> `otp`=8'h87 and `otp_valid`=1 stable throughout; LFSR stays 16'hC2C4. Release -> next byte 9 cycles later.
4. `seed_load` at GEN step 4 -> partial byte dropped, `busy`=0 next cycle, and the next byte is again 8'h87.
5. `enable`=0 at GEN step 3 -> the byte completes; after the handshake the block stays in ARMED and `otp_valid` stays 0.
6. Guard on, seed 16'hACE1, free-running -> 8191 bytes delivered, then `exhausted`=1 on the 7th step of byte 8192 with no `otp_valid`. `seed_load` clears the flag. Guard off -> byte 8192 is delivered and `exhausted` stays 0.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad keystream generator.
// The EXHAUSTED state exists only when OTP_GEN_REUSE_GUARD_EN is defined.
package otp_pkg;

   localparam int          OTP_W            = 8;
   localparam logic [15:0] OTP_TAPS         = 16'hB400;
   localparam logic [15:0] OTP_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_GEN,
      ST_HOLD
`ifdef OTP_GEN_REUSE_GUARD_EN
      ,
      ST_EXHAUSTED
`endif
   } otp_state_t;

endpackage

// File: rtl/otp_lfsr_core.sv
// Seeded Galois LFSR: one right-shift step per strobe, all-zero seed replaced by the default.
module otp_lfsr_core
   import otp_pkg::*;
#(
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = OTP_TAPS,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = OTP_DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state,
   output logic              step_bit
);

   logic [LFSR_W-1:0] nxt;

   assign step_bit = state[0];
   assign nxt      = (state >> 1) ^ (state[0] ? TAPS : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DEFAULT_SEED;
      end else if (load) begin
         // an all-zero state would lock the register up
         state <= (seed == '0) ? DEFAULT_SEED : seed;
      end else if (step) begin
         state <= nxt;
      end
   end

endmodule

// File: rtl/otp_keystream_gen.sv
// Keystream byte generator: serialises the LFSR into bytes behind a valid/ready handshake.
// Define OTP_GEN_REUSE_GUARD_EN to stop with a sticky flag when the LFSR returns to its seed.
module otp_keystream_gen
   import otp_pkg::*;
#(
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = OTP_TAPS,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = OTP_DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              enable,
   input  logic              otp_ready,
   output logic              otp_valid,
   output logic [OTP_W-1:0]  otp,
   output logic              busy,
   output logic              exhausted
);

   otp_state_t        fsm;
   logic [2:0]        bit_cnt;
   logic [OTP_W-2:0]  sr;
   logic [LFSR_W-1:0] lfsr_state;
   logic              step_bit;
   logic              lfsr_step;

   assign lfsr_step = (fsm == ST_GEN) && !seed_load;

   otp_lfsr_core #(
      .LFSR_W       (LFSR_W),
      .TAPS         (TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .step     (lfsr_step),
      .seed     (seed),
      .state    (lfsr_state),
      .step_bit (step_bit)
   );

`ifdef OTP_GEN_REUSE_GUARD_EN
   logic [LFSR_W-1:0] seed_reg;
   logic [LFSR_W-1:0] seed_eff;
   logic [LFSR_W-1:0] lfsr_nxt;
   logic              reuse_hit;

   assign seed_eff  = (seed == '0) ? DEFAULT_SEED : seed;
   assign lfsr_nxt  = (lfsr_state >> 1) ^ (lfsr_state[0] ? TAPS : '0);
   assign reuse_hit = (lfsr_nxt == seed_reg);
`else
   logic unused_state;
   assign unused_state = ^lfsr_state;
   assign exhausted    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         bit_cnt   <= '0;
         sr        <= '0;
         otp       <= '0;
         otp_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef OTP_GEN_REUSE_GUARD_EN
         exhausted <= 1'b0;
         seed_reg  <= DEFAULT_SEED;
`endif
      end else if (seed_load) begin
         // a byte handed over in this same cycle is already the consumer's; otp is left as is
         fsm       <= ST_ARMED;
         bit_cnt   <= '0;
         sr        <= '0;
         otp_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef OTP_GEN_REUSE_GUARD_EN
         exhausted <= 1'b0;
         seed_reg  <= seed_eff;
`endif
      end else begin
         case (fsm)
            ST_ARMED: begin
               if (enable) begin
                  fsm  <= ST_GEN;
                  busy <= 1'b1;
               end
            end
            ST_GEN: begin
               sr      <= {sr[OTP_W-3:0], step_bit};
               bit_cnt <= bit_cnt + 3'd1;
`ifdef OTP_GEN_REUSE_GUARD_EN
               if (reuse_hit) begin
                  fsm       <= ST_EXHAUSTED;
                  busy      <= 1'b0;
                  exhausted <= 1'b1;
                  sr        <= '0;
                  bit_cnt   <= '0;
               end else
`endif
               if (bit_cnt == 3'd7) begin
                  fsm       <= ST_HOLD;
                  otp       <= {sr, step_bit};
                  otp_valid <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (otp_valid && otp_ready) begin
                  otp_valid <= 1'b0;
                  if (enable) begin
                     fsm  <= ST_GEN;
                     busy <= 1'b1;
                  end else begin
                     fsm <= ST_ARMED;
                  end
               end
            end
            default: begin
               // IDLE waits for a seed; EXHAUSTED leaves only via seed_load or reset
               fsm <= fsm;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_otp_keystream_gen.sv
// Scoreboard bench for otp_keystream_gen; an independent LFSR model predicts every byte.
// Also covers the reuse guard when built with OTP_GEN_REUSE_GUARD_EN.
module tb_otp_keystream_gen;
   import otp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [15:0] seed;
   logic        enable;
   logic        otp_ready;
   logic        otp_valid;
   logic [7:0]  otp;
   logic        busy;
   logic        exhausted;

   int          total = 0;
   int          bad = 0;
   int          n_rx = 0;
   logic [15:0] mdl;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   otp_keystream_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (seed_load),
      .seed      (seed),
      .enable    (enable),
      .otp_ready (otp_ready),
      .otp_valid (otp_valid),
      .otp       (otp),
      .busy      (busy),
      .exhausted (exhausted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // model: Galois right shift, first bit into the MSB of the byte
   task automatic push_bytes(input int n);
      logic [7:0] b;
      logic       x;
      for (int k = 0; k < n; k++) begin
         b = '0;
         for (int j = 0; j < 8; j++) begin
            x   = mdl[0];
            mdl = (mdl >> 1) ^ (x ? 16'hB400 : 16'h0000);
            b   = {b[6:0], x};
         end
         exp_q.push_back(b);
      end
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed      = s;
      seed_load = 1'b1;
      exp_q.delete();
      mdl = (s == 16'h0000) ? 16'hACE1 : s;
      @(posedge clk);
      #1;
      seed_load = 1'b0;
   endtask

   // counts rising edges until otp_valid is seen; returns on the falling edge
   task automatic wait_valid(input string tag, input int exp_n);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 64) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = otp_valid;
      end
      chk(tag, seen ? n : -1, exp_n);
   endtask

   always @(negedge clk) begin
      if (rst_n && otp_valid && otp_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_byte", {24'd0, otp}, 32'hFFFF_FFFF);
         end else begin
            chk("byte", {24'd0, otp}, {24'd0, exp_q.pop_front()});
         end
         n_rx++;
      end
   end

   initial begin
      int n;
      bit hit;
      rst_n     = 1'b0;
      seed_load = 1'b0;
      seed      = '0;
      enable    = 1'b0;
      otp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", otp_valid, 0);
      chk("rst_otp", otp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_exh", exhausted, 0);
      chk("rst_lfsr", dut.lfsr_state, 16'hACE1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      enable = 1'b1;
      otp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);

      // first byte from the default seed
      load_seed(16'hACE1);
      push_bytes(1);
      chk("armed_valid", otp_valid, 0);
      wait_valid("lat_t1", 9);
      chk("lfsr_t1", dut.lfsr_state, 16'hC2C4);
      chk("otp_t1", otp, 8'h87);
      enable = 1'b0;
      @(posedge clk);
      #1;

      // zero seed behaves like the default seed
      enable = 1'b1;
      load_seed(16'h0000);
      push_bytes(1);
      wait_valid("lat_t2", 9);
      enable = 1'b0;
      @(posedge clk);
      #1;

      // consumer stalls, byte and LFSR frozen
      otp_ready = 1'b0;
      enable = 1'b1;
      load_seed(16'hACE1);
      push_bytes(2);
      wait_valid("lat_t3", 9);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold", {7'd0, otp_valid, otp, dut.lfsr_state}, {7'd0, 1'b1, 8'h87, 16'hC2C4});
      end
      @(posedge clk);
      #1;
      otp_ready = 1'b1;
      wait_valid("lat_t3b", 9);
      enable = 1'b0;
      @(posedge clk);
      #1;

      // reseed mid-byte
      enable = 1'b1;
      load_seed(16'hACE1);
      repeat (4) @(posedge clk);
      #1;
      chk("busy_gen", busy, 1);
      load_seed(16'hACE1);
      chk("busy_reseed", busy, 0);
      chk("valid_reseed", otp_valid, 0);
      push_bytes(1);
      wait_valid("lat_t4", 9);
      enable = 1'b0;
      @(posedge clk);
      #1;

      // enable dropped mid-byte
      enable = 1'b1;
      load_seed(16'h1234);
      push_bytes(1);
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b0;
      wait_valid("lat_t5", 6);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("stopped", {30'd0, otp_valid, busy}, 0);
      end
      chk("q_t5", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // free-running through the full LFSR period
      enable = 1'b1;
      otp_ready = 1'b1;
      n_rx = 0;
      load_seed(16'hACE1);
`ifdef OTP_GEN_REUSE_GUARD_EN
      push_bytes(8191);
`else
      push_bytes(8192);
`endif
      n = 0;
      hit = 1'b0;
      while (!hit && n < 8192 * 9 + 100) begin
         @(posedge clk);
         #1;
         n++;
`ifdef OTP_GEN_REUSE_GUARD_EN
         hit = exhausted;
`else
         hit = (n_rx == 8192);
`endif
      end
      chk("period_reached", hit, 1);
`ifdef OTP_GEN_REUSE_GUARD_EN
      chk("exh_cycle", n, 73727);
      chk("exh_bytes", n_rx, 8191);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("exh_hold", {29'd0, exhausted, otp_valid, busy}, 32'd4);
      end
      @(posedge clk);
      #1;
      load_seed(16'hACE1);
      chk("exh_clear", exhausted, 0);
`else
      chk("noexh", exhausted, 0);
      enable = 1'b0;
      otp_ready = 1'b0;
      chk("q_t6", exp_q.size(), 0);
      load_seed(16'hACE1);
      chk("noexh_after", exhausted, 0);
`endif
      chk("q_end", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
